// File: rtl/card_code_reader.sv
// Serial card-reader front end: deserialises start/data/parity/stop frames into an
// access code with a one-cycle validate strobe, and flags and counts malformed frames.
module card_code_reader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CODE_W       = 4
) (
    input  logic              clk,
    input  logic              rset,
    input  logic              card_rx,
    output logic [CODE_W-1:0] access_code,
    output logic              validate_code,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(CODE_W + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] CODE_LAST = BIT_W'(CODE_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t            state, state_nxt;
    logic              rx_m, rx_s;
    logic [CNT_W-1:0]  clk_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CODE_W-1:0] shreg;
    logic              parity_ok;
    logic              cnt_clr, shift_en, par_en, good_frame, bad_frame;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser, preset to the idle-high line level
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= card_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rset) begin
        if (rset) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_nxt = START;
                cnt_clr   = 1'b1;
            end
            START: if (clk_cnt == HALF_LAST) begin
                cnt_clr   = 1'b1;
                state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: if (clk_cnt == BIT_LAST) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_cnt == CODE_LAST) state_nxt = PARITY;
            end
            PARITY: if (clk_cnt == BIT_LAST) begin
                cnt_clr   = 1'b1;
                par_en    = 1'b1;
                state_nxt = STOP;
            end
            STOP: if (clk_cnt == BIT_LAST) begin
                cnt_clr = 1'b1;
                if (rx_s) begin
                    state_nxt  = IDLE;
                    good_frame = parity_ok;
                    bad_frame  = !parity_ok;
                end else begin
                    // Line still low at the stop sample: wait for it to release
                    state_nxt = BREAK;
                    bad_frame = 1'b1;
                end
            end
            BREAK: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            parity_ok     <= 1'b0;
            access_code   <= '0;
            validate_code <= 1'b0;
            frame_err     <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            clk_cnt       <= cnt_clr ? '0 : clk_cnt + 1'b1;
            if (state != DATA)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
            if (par_en)         parity_ok <= ~(^shreg ^ rx_s);
            validate_code <= good_frame;
            frame_err     <= bad_frame;
            if (good_frame)     access_code <= shreg;
            if (bad_frame)      err_count <= sat_inc(err_count);
        end
    end

    // LSB arrives first, so shift in from the top
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[CODE_W-1:1]};
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_card_code_reader.sv
// Bench for card_code_reader: vector table, hand-written corner sequences and random
// frames checked against a frame-level outcome model.
module tb_card_code_reader;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rset = 1'b1;
    logic       card_rx = 1'b1;
    logic [3:0] access_code;
    logic       validate_code, frame_err, busy;
    logic [7:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    int nval = 0, nerr = 0, cyc = 0;
    int val_cyc[$];
    int exp_code = 0, exp_errcnt = 0;

    card_code_reader #(.CLKS_PER_BIT(CPB), .CODE_W(4)) dut (
        .clk(clk), .rset(rset), .card_rx(card_rx), .access_code(access_code),
        .validate_code(validate_code), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] code;
        bit         par_flip;
        bit         stop;
        int         dv;
        int         de;
        int         ecode;
        int         ecnt;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        bit pv = 0, pe = 0;
        forever begin
            @(negedge clk);
            if (validate_code || frame_err) begin
                check("strobe_excl", int'(validate_code && frame_err), 0);
                check("strobe_width", int'((validate_code && pv) || (frame_err && pe)), 0);
            end
            if (validate_code) begin
                nval++;
                val_cyc.push_back(cyc);
            end
            if (frame_err) nerr++;
            pv = validate_code;
            pe = frame_err;
        end
    end

    task automatic send_bit(input bit b);
        card_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] code, input bit par_flip, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(code[i]);
        send_bit(^code ^ par_flip);
        send_bit(stop);
    endtask

    task automatic settle();
        card_rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic frame_check(input string tag, input int v0, input int e0,
                               input int dv, input int de, input int ecode, input int ecnt);
        check({tag, "_valid"}, nval - v0, dv);
        check({tag, "_err"}, nerr - e0, de);
        check({tag, "_code"}, int'(access_code), ecode);
        check({tag, "_errcnt"}, int'(err_count), ecnt);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Frame-level outcome: good parity and high stop updates the code, anything else is an error
    task automatic model_frame(input logic [3:0] code, input bit par_flip, input bit stop);
        if (stop && !par_flip) exp_code = int'(code);
        else if (exp_errcnt < 255) exp_errcnt++;
    endtask

    initial begin
        vec_t tbl[8];
        int v0, e0;
        tbl[0] = '{4'd9,  1'b1, 1'b1, 0, 1, 0,  1};
        tbl[1] = '{4'd9,  1'b0, 1'b1, 1, 0, 9,  1};
        tbl[2] = '{4'd6,  1'b0, 1'b1, 1, 0, 6,  1};
        tbl[3] = '{4'd6,  1'b1, 1'b1, 0, 1, 6,  2};
        tbl[4] = '{4'd0,  1'b0, 1'b1, 1, 0, 0,  2};
        tbl[5] = '{4'd15, 1'b0, 1'b1, 1, 0, 15, 2};
        tbl[6] = '{4'd15, 1'b1, 1'b1, 0, 1, 15, 3};
        tbl[7] = '{4'd5,  1'b0, 1'b0, 0, 1, 15, 4};

        repeat (3) @(posedge clk);
        #1;
        check("rst_code", int'(access_code), 0);
        check("rst_valid", int'(validate_code), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_errcnt", int'(err_count), 0);
        check("rst_busy", int'(busy), 0);
        rset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            v0 = nval; e0 = nerr;
            send_frame(tbl[i].code, tbl[i].par_flip, tbl[i].stop);
            settle();
            frame_check($sformatf("tbl%0d", i), v0, e0, tbl[i].dv, tbl[i].de, tbl[i].ecode, tbl[i].ecnt);
        end
        exp_code = 15; exp_errcnt = 4;

        // Stop bit low with the line held low: one error, stuck in BREAK until release
        v0 = nval; e0 = nerr;
        send_frame(4'd5, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("brk_busy", int'(busy), 1);
        check("brk_err", nerr - e0, 1);
        repeat (10) @(posedge clk);
        #1;
        check("brk_still_busy", int'(busy), 1);
        check("brk_no_retrigger", nerr - e0, 1);
        exp_errcnt++;
        settle();
        frame_check("brk_release", v0, e0, 0, 1, exp_code, exp_errcnt);
        v0 = nval; e0 = nerr;
        send_frame(4'd3, 1'b0, 1'b1);
        settle();
        exp_code = 3;
        frame_check("after_brk", v0, e0, 1, 0, 3, exp_errcnt);

        // One-cycle glitch on the line
        v0 = nval; e0 = nerr;
        card_rx = 1'b0;
        @(posedge clk);
        #1;
        card_rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        frame_check("glitch", v0, e0, 0, 0, exp_code, exp_errcnt);

        // Back-to-back frames, no idle gap
        v0 = nval; e0 = nerr;
        send_frame(4'd9, 1'b0, 1'b1);
        send_frame(4'd6, 1'b0, 1'b1);
        settle();
        exp_code = 6;
        frame_check("b2b", v0, e0, 2, 0, 6, exp_errcnt);
        if (val_cyc.size() >= 2)
            check("b2b_spacing", val_cyc[val_cyc.size()-1] - val_cyc[val_cyc.size()-2], 28);
        else
            check("b2b_pulses", val_cyc.size(), 2);

        // Randomised frames against the outcome model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] c;
            bit pf, sb;
            int edv, ede;
            c  = 4'($urandom_range(0, 15));
            pf = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) != 0);
            v0 = nval; e0 = nerr;
            edv = (sb && !pf) ? 1 : 0;
            ede = 1 - edv;
            send_frame(c, pf, sb);
            if (!sb) repeat ($urandom_range(0, 10)) @(posedge clk);
            #1;
            model_frame(c, pf, sb);
            settle();
            frame_check($sformatf("rnd%0d", i), v0, e0, edv, ede, exp_code, exp_errcnt);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of the data bits
        v0 = nval; e0 = nerr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        rset = 1'b1;
        #1;
        check("mid_rst_code", int'(access_code), 0);
        check("mid_rst_errcnt", int'(err_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_strobes", int'(validate_code) + int'(frame_err), 0);
        card_rx = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        exp_code = 0; exp_errcnt = 0;
        frame_check("post_rst", v0, e0, 0, 0, 0, 0);
        v0 = nval; e0 = nerr;
        send_frame(4'd12, 1'b0, 1'b1);
        settle();
        exp_code = 12;
        frame_check("code12", v0, e0, 1, 0, 12, 0);

        // Error counter saturation
        for (int i = 0; i < 257; i++) begin
            e0 = nerr;
            send_frame(4'd9, 1'b1, 1'b1);
            card_rx = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            model_frame(4'd9, 1'b1, 1'b1);
            check($sformatf("sat%0d_err", i), nerr - e0, 1);
            check($sformatf("sat%0d_cnt", i), int'(err_count), exp_errcnt);
        end
        check("sat_final", int'(err_count), 255);
        check("sat_code_held", int'(access_code), 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/card_code_reader.md
Name: card_code_reader

Overview:
- Upstream stage of the metro turnstile FSM.
- Deserialises the framed serial bit stream from the card/token reader head into a 4-bit access code.
- Presents the code with a one-cycle validate_code strobe; the strobe and code connect directly to the turnstile's validate_code/access_code inputs.
- Rejects malformed frames, flags them, and counts them for maintenance readout.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range ≥ 2. Mid-bit offset is floor(CLKS_PER_BIT/2).
- CODE_W, 4, data bits per frame; equals the access_code width.

Ports:
- clk  input  1  system clock, rising-edge.
- rset  input  1  asynchronous, active-high reset.
- card_rx  input  1  serial line from the reader head. Asynchronous to clk; idles high.
- access_code  output  CODE_W  last valid code received; held until the next valid frame.
- validate_code  output  1  one-cycle strobe when access_code has just been updated.
- frame_err  output  1  one-cycle strobe on a rejected frame (parity or stop-bit error).
- err_count  output  8  saturating count of rejected frames.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rset=1, asynchronous):
  - access_code=0, validate_code=0, frame_err=0, err_count=0, busy=0.
  - FSM goes to IDLE; bit and clock counters clear.
  - Both card_rx synchroniser flops are set to 1 (idle level).
  - Reset mid-frame discards the partial frame with no strobe.
- Synchroniser: card_rx passes through 2 flops. All FSM decisions use the synchronised value rx_s, which lags card_rx by 2 cycles.
- Frame format, LSB first:
  - start bit (0), then CODE_W data bits, then even-parity bit, then stop bit (1).
  - Even parity: XOR of data bits and parity bit = 0.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rx_s=0, go to START and clear the clock counter.
  - START: wait floor(CLKS_PER_BIT/2)−1 further cycles, then sample.
    - rx_s=1 at the sample → glitch; return to IDLE with no error and no count.
    - rx_s=0 → go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles; shift bits into the shift register LSB-first. After CODE_W samples, go to PARITY.
  - PARITY: sample one bit time later; latch parity_ok. Go to STOP.
  - STOP: sample one bit time later.
    - rx_s=1 and parity_ok → access_code ← shift register and validate_code=1 on the same edge. Go to IDLE.
    - rx_s=1 and parity bad → frame_err=1, err_count+1. Go to IDLE.
    - rx_s=0 (framing error) → frame_err=1, err_count+1. Go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line from re-triggering start.
- Strobe rules:
  - validate_code and frame_err are each exactly 1 cycle wide and never high together.
  - access_code does not change on error frames.
- err_count saturates at 255; further errors still pulse frame_err.
- Back-to-back frames: a start edge on rx_s is accepted in IDLE on the cycle right after the stop sample; no idle gap is required beyond the stop bit.
- Latency: a stop-bit edge on card_rx at cycle T gives validate_code at cycle T+2+floor(CLKS_PER_BIT/2), ±1 for the asynchronous sample phase.
- card_rx changes mid-bit are ignored; only the mid-bit sample counts. There is no majority voting.

Test Plan (CLKS_PER_BIT=4):
1. Valid code 9. Drive start 0; data 1,0,0,1; parity 0; stop 1; 4 cycles per bit.
   → access_code=4'b1001, validate_code high exactly 1 cycle, frame_err=0, busy low afterwards.
2. Parity error, code 9. Same frame with parity=1.
   → frame_err pulses once, err_count=1, access_code stays at the previous value (0 after reset), validate_code never asserts.
3. Framing error, code 5. Frame with stop=0, line held low 20 cycles, then high.
   → frame_err once, err_count=1, FSM in BREAK while low; no new start detected until the line returns high. A following valid code 3 frame then gives access_code=4'b0011.
4. Glitch and back-to-back.
   - card_rx low for 1 cycle → no strobe, busy returns to 0, err_count unchanged.
   - Then codes 9 and 6 sent with no gap → two validate_code pulses 28 cycles apart; access_code 1001 then 0110.
5. Reset mid-frame. Assert rset during DATA of a code-9 frame.
   → all outputs 0 immediately (asynchronously); no strobe. After release, a clean code-12 frame → access_code=4'b1100.
6. Saturation. Send 257 parity-error frames.
   → err_count=255 and holds; frame_err pulses on every frame including the 256th and 257th.
